// File: rtl/limn2600_bus_master.sv
// limn2600_bus_master: Limn2600 SRAM-bus initiator with sub-word RMW stores, alignment checks and rdy timeout
module limn2600_bus_master #(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_RDATA      = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        bus_cs,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rdy
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, RESP} state_t;

    state_t         state, state_d;
    logic           we_q;
    logic [1:0]     size_q, lane_q;
    logic [31:0]    wdata_q;
    logic [CW-1:0]  cnt, cnt_d;
    logic [31:0]    addr_d, wdata_d, rdata_d;
    logic           err_d, accept, bad, timeout, rmw;
    logic [4:0]     sh;
    logic [31:0]    mask, loaded, merged;

    assign accept  = state == IDLE && req_ready && req_valid;
    assign bad     = req_size == 2'd3 || (req_size == 2'd1 && req_addr[0]) || (req_size == 2'd2 && req_addr[1:0] != 2'd0);
    assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
    assign rmw     = state == RD_WAIT && we_q;
    assign sh      = {lane_q, 3'b000};
    assign mask    = size_q == 2'd0 ? 32'h000000ff : size_q == 2'd1 ? 32'h0000ffff : 32'hffffffff;
    assign loaded  = (bus_rdata >> sh) & mask;
    assign merged  = (bus_rdata & ~(mask << sh)) | ((wdata_q & mask) << sh);

    // Next state plus the values the registered outputs take on the coming edge
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        addr_d  = bus_addr;
        wdata_d = bus_wdata;
        rdata_d = 32'd0;
        err_d   = 1'b0;
        case (state)
            IDLE: if (accept) begin
                addr_d  = {req_addr[31:2], 2'b00};
                wdata_d = req_wdata;
                err_d   = bad;
                rdata_d = bad ? ERR_RDATA : 32'd0;
                state_d = bad ? RESP : (req_we && req_size == 2'd2) ? WR_ISSUE : RD_ISSUE;
            end
            RD_ISSUE: begin
                state_d = RD_WAIT;
                cnt_d   = '0;
            end
            WR_ISSUE: begin
                state_d = WR_WAIT;
                cnt_d   = '0;
            end
            RD_WAIT, WR_WAIT: if (bus_rdy) begin
                state_d = rmw ? WR_ISSUE : RESP;
                wdata_d = rmw ? merged : bus_wdata;
                rdata_d = state == RD_WAIT && !we_q ? loaded : 32'd0;
            end else if (timeout) begin
                state_d = RESP;
                err_d   = 1'b1;
                rdata_d = ERR_RDATA;
            end else begin
                cnt_d = cnt + 1'b1;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // Registered outputs, timeout counter and latched request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            bus_cs     <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'd0;
            bus_wdata  <= 32'd0;
            cnt        <= '0;
            we_q       <= 1'b0;
            size_q     <= 2'd0;
            lane_q     <= 2'd0;
            wdata_q    <= 32'd0;
        end else begin
            req_ready  <= state_d == IDLE;
            resp_valid <= state_d == RESP;
            resp_rdata <= state_d == RESP ? rdata_d : 32'd0;
            resp_err   <= state_d == RESP && err_d;
            bus_cs     <= state_d == RD_ISSUE || state_d == WR_ISSUE;
            bus_we     <= state_d == WR_ISSUE;
            bus_addr   <= addr_d;
            bus_wdata  <= wdata_d;
            cnt        <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                lane_q  <= req_addr[1:0];
                wdata_q <= req_wdata;
            end
        end
    end
endmodule
